// File: rtl/branch_predictor_btb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_predictor_btb                                            |
// | Brief    : Direct-mapped BTB with saturating direction counters, trained   |
// |            from EX, zero-latency IF lookup, mispredict/redirect and perf.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module branch_predictor_btb #(
    parameter int ADDR_W    = 32,
    parameter int ENTRIES   = 16,
    parameter int CNT_W     = 2,
    parameter int PRED_MODE = 1,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              lkp_hit,
    output logic              lkp_taken,
    output logic [ADDR_W-1:0] lkp_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_is_branch,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_npc,
    output logic              upd_mispredict,
    output logic [ADDR_W-1:0] upd_redirect_pc,
    input  logic              inv,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);
    localparam int               c_IDX_W     = $clog2(ENTRIES);
    localparam int               c_TAG_W     = ADDR_W - c_IDX_W - 2;
    localparam logic [CNT_W-1:0] c_cntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cntWeakT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] c_cntWeakNT = c_cntWeakT - CNT_W'(1);
    localparam logic [PERF_W-1:0] c_perfMax  = {PERF_W{1'b1}};
    localparam logic             c_dynamic   = (PRED_MODE == 1);

    logic [ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];
    logic [PERF_W-1:0]  r_branchCnt;
    logic [PERF_W-1:0]  r_mispredCnt;

    logic [c_IDX_W-1:0] w_lkpIdx;
    logic [c_TAG_W-1:0] w_lkpTag;
    logic [c_IDX_W-1:0] w_updIdx;
    logic [c_TAG_W-1:0] w_updTag;
    logic               w_updHit;
    logic [ADDR_W-1:0]  w_corrNpc;
    logic               w_unusedBits;

    // Byte-offset bits and the carried direction do not influence any decision.
    assign w_unusedBits = ^{lkp_pc[1:0], upd_pc[1:0], upd_pred_taken};

    assign w_lkpIdx    = lkp_pc[c_IDX_W+1:2];
    assign w_lkpTag    = lkp_pc[ADDR_W-1:c_IDX_W+2];
    assign lkp_hit     = r_valid[w_lkpIdx] && (r_tag[w_lkpIdx] == w_lkpTag);
    assign lkp_taken   = lkp_hit && r_cnt[w_lkpIdx][CNT_W-1] && c_dynamic;
    assign lkp_next_pc = lkp_taken ? r_target[w_lkpIdx] : lkp_pc + ADDR_W'(4);

    assign w_updIdx  = upd_pc[c_IDX_W+1:2];
    assign w_updTag  = upd_pc[ADDR_W-1:c_IDX_W+2];
    assign w_updHit  = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);
    assign w_corrNpc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + ADDR_W'(4);

    // Only a wrong next PC costs a flush; a direction mismatch landing on the same PC does not.
    assign upd_mispredict  = upd_valid && (upd_pred_npc != w_corrNpc);
    assign upd_redirect_pc = w_corrNpc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= c_cntWeakNT;
            end
        end else if (inv) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (upd_is_branch) begin
                if (w_updHit) begin
                    if (upd_taken) begin
                        if (r_cnt[w_updIdx] != c_cntMax)
                            r_cnt[w_updIdx] <= r_cnt[w_updIdx] + CNT_W'(1);
                        r_target[w_updIdx] <= upd_target;
                    end else if (r_cnt[w_updIdx] != '0) begin
                        r_cnt[w_updIdx] <= r_cnt[w_updIdx] - CNT_W'(1);
                    end
                end else if (upd_taken) begin
                    r_valid[w_updIdx]  <= 1'b1;
                    r_tag[w_updIdx]    <= w_updTag;
                    r_target[w_updIdx] <= upd_target;
                    r_cnt[w_updIdx]    <= c_cntWeakT;
                end
            end else if (w_updHit) begin
                // A non-branch matching an entry means the entry is stale.
                r_valid[w_updIdx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branchCnt  <= '0;
            r_mispredCnt <= '0;
        end else begin
            if (upd_valid && upd_is_branch && (r_branchCnt != c_perfMax))
                r_branchCnt <= r_branchCnt + PERF_W'(1);
            if (upd_mispredict && (r_mispredCnt != c_perfMax))
                r_mispredCnt <= r_mispredCnt + PERF_W'(1);
        end
    end

    assign branch_cnt  = r_branchCnt;
    assign mispred_cnt = r_mispredCnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_predictor_btb                                         |
// | Brief    : Directed + random bench for two BTB configurations.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_branch_predictor_btb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] lkp_pc = 32'h0040_0000;
    logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0, inv = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_npc = '0;

    logic        hit0, tk0, mp0, hit1, tk1, mp1;
    logic [31:0] npc0, rd0, bc0, mc0, npc1, rd1;
    logic [3:0]  bc1, mc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_btb dut0 (
        .clk(clk), .rst(rst), .lkp_pc(lkp_pc), .lkp_hit(hit0), .lkp_taken(tk0), .lkp_next_pc(npc0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
        .upd_mispredict(mp0), .upd_redirect_pc(rd0), .inv(inv), .branch_cnt(bc0), .mispred_cnt(mc0));

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(64), .CNT_W(3), .PRED_MODE(0), .PERF_W(4)) dut1 (
        .clk(clk), .rst(rst), .lkp_pc(lkp_pc), .lkp_hit(hit1), .lkp_taken(tk1), .lkp_next_pc(npc1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
        .upd_mispredict(mp1), .upd_redirect_pc(rd1), .inv(inv), .branch_cnt(bc1), .mispred_cnt(mc1));

    // Reference model: each slot remembers the full word address of the branch it holds.
    int          ents [2] = '{16, 64};
    int          cw   [2] = '{2, 3};
    int          pm   [2] = '{1, 0};
    longint      pmax [2] = '{64'hFFFF_FFFF, 15};
    bit          m_valid [2][64];
    int unsigned m_word  [2][64];
    logic [31:0] m_tgt   [2][64];
    int          m_cnt   [2][64];
    longint      m_br [2];
    longint      m_mp [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 64; j++) begin
                m_valid[c][j] = 1'b0;
                m_word[c][j]  = 0;
                m_tgt[c][j]   = '0;
                m_cnt[c][j]   = (1 << (cw[c] - 1)) - 1;
            end
            m_br[c] = 0;
            m_mp[c] = 0;
        end
    endtask

    task automatic predict(input int c, input logic [31:0] pc, output logic h, output logic t,
                           output logic [31:0] n);
        int idx;
        idx = int'(pc >> 2) % ents[c];
        h = m_valid[c][idx] && (m_word[c][idx] == int'(pc >> 2));
        t = h && (m_cnt[c][idx] >= (1 << (cw[c] - 1))) && (pm[c] == 1);
        n = t ? m_tgt[c][idx] : pc + 32'd4;
    endtask

    function automatic logic [31:0] correct_npc();
        return (upd_is_branch && upd_taken) ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic check_all();
        logic h, t, mp;
        logic [31:0] n, corr;
        corr = correct_npc();
        mp   = upd_valid && (upd_pred_npc != corr);
        predict(0, lkp_pc, h, t, n);
        chk("hit0", hit0, h);  chk("taken0", tk0, t);  chk("npc0", npc0, n);
        chk("mp0", mp0, mp);   chk("redir0", rd0, corr);
        chk("brcnt0", bc0, m_br[0]); chk("mpcnt0", mc0, m_mp[0]);
        predict(1, lkp_pc, h, t, n);
        chk("hit1", hit1, h);  chk("taken1", tk1, t);  chk("npc1", npc1, n);
        chk("mp1", mp1, mp);   chk("redir1", rd1, corr);
        chk("brcnt1", bc1, m_br[1]); chk("mpcnt1", mc1, m_mp[1]);
    endtask

    task automatic train();
        logic [31:0] corr;
        corr = correct_npc();
        for (int c = 0; c < 2; c++) begin
            int idx;
            bit h;
            idx = int'(upd_pc >> 2) % ents[c];
            h   = m_valid[c][idx] && (m_word[c][idx] == int'(upd_pc >> 2));
            if (upd_valid && upd_is_branch && m_br[c] < pmax[c]) m_br[c]++;
            if (upd_valid && (upd_pred_npc != corr) && m_mp[c] < pmax[c]) m_mp[c]++;
            if (inv) begin
                for (int j = 0; j < 64; j++) m_valid[c][j] = 1'b0;
            end else if (upd_valid) begin
                if (upd_is_branch) begin
                    if (h) begin
                        if (upd_taken) begin
                            if (m_cnt[c][idx] < (1 << cw[c]) - 1) m_cnt[c][idx]++;
                            m_tgt[c][idx] = upd_target;
                        end else if (m_cnt[c][idx] > 0) begin
                            m_cnt[c][idx]--;
                        end
                    end else if (upd_taken) begin
                        m_valid[c][idx] = 1'b1;
                        m_word[c][idx]  = int'(upd_pc >> 2);
                        m_tgt[c][idx]   = upd_target;
                        m_cnt[c][idx]   = 1 << (cw[c] - 1);
                    end
                end else if (h) begin
                    m_valid[c][idx] = 1'b0;
                end
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) train(); else model_reset();
        #1;
    endtask

    task automatic step();
        half();
        tick();
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pnpc);
        upd_valid = v; upd_pc = pc; upd_is_branch = br; upd_taken = tk;
        upd_target = tgt; upd_pred_npc = pnpc; upd_pred_taken = (pnpc != pc + 32'd4);
    endtask

    task automatic br_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        set_upd(1'b1, pc, 1'b1, tk, tgt, pc + 32'd4);
        step();
    endtask

    initial begin
        logic [31:0] pcr, pn;
        logic        h, t;
        model_reset();

        // T1: reset state
        half();
        chk("T1 hit", hit0, 1'b0);
        chk("T1 npc", npc0, 32'h0040_0004);
        chk("T1 brcnt", bc0, 32'd0);
        chk("T1 mpcnt", mc0, 32'd0);
        tick();
        rst = 1'b1;

        // T2: allocate on a mispredicted taken branch
        set_upd(1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0014);
        half();
        chk("T2 mp", mp0, 1'b1);
        chk("T2 redir", rd0, 32'h0040_0040);
        tick();
        upd_valid = 1'b0;
        lkp_pc = 32'h0040_0010;
        half();
        chk("T2 hit", hit0, 1'b1);
        chk("T2 taken", tk0, 1'b1);
        chk("T2 npc", npc0, 32'h0040_0040);
        chk("T2 static hit", hit1, 1'b1);
        chk("T2 static taken", tk1, 1'b0);
        tick();

        // T3: hysteresis 2->1->0, recovery, saturation
        br_upd(32'h0040_0010, 1'b0, 32'h0);
        half(); chk("T3 after 1 NT", tk0, 1'b0); tick();
        br_upd(32'h0040_0010, 1'b0, 32'h0);
        br_upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        half(); chk("T3 after 1 T", tk0, 1'b0); tick();
        br_upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        half(); chk("T3 after 2 T", tk0, 1'b1); tick();
        repeat (4) br_upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        br_upd(32'h0040_0010, 1'b0, 32'h0);
        half(); chk("T3 saturated", tk0, 1'b1); tick();

        // T4: tag alias, then non-branch invalidation
        upd_valid = 1'b0;
        lkp_pc = 32'h0040_0050;
        half(); chk("T4 alias hit", hit0, 1'b0); tick();
        set_upd(1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0040_0014);
        step();
        upd_valid = 1'b0;
        lkp_pc = 32'h0040_0010;
        half(); chk("T4 invalidated", hit0, 1'b0); tick();

        // Address-space wrap of the fall-through PC
        lkp_pc = 32'hFFFF_FFFC;
        half(); chk("wrap npc", npc0, 32'h0); tick();

        // T5: invalidate beats a same-cycle allocate; read-before-write
        inv = 1'b1;
        br_upd(32'h0040_0020, 1'b1, 32'h0000_0100);
        inv = 1'b0;
        upd_valid = 1'b0;
        lkp_pc = 32'h0040_0020;
        half(); chk("T5 inv wins", hit0, 1'b0); tick();
        set_upd(1'b1, 32'h0040_0030, 1'b1, 1'b1, 32'h0000_0200, 32'h0040_0034);
        lkp_pc = 32'h0040_0030;
        half(); chk("T5 old contents", hit0, 1'b0); tick();
        upd_valid = 1'b0;
        half(); chk("T5 new contents", hit0, 1'b1); tick();

        // Async reset in the middle of an update cycle
        set_upd(1'b1, 32'h0040_0060, 1'b1, 1'b1, 32'h0000_0300, 32'h0040_0064);
        #2 rst = 1'b0;
        #1 model_reset();
        chk("rst hit", hit0, 1'b0);
        chk("rst brcnt", bc0, 32'd0);
        chk("rst static brcnt", bc1, 4'd0);
        tick();
        #2 rst = 1'b1;
        upd_valid = 1'b0;
        lkp_pc = 32'h0040_0060;
        half(); chk("rst no partial", hit0, 1'b0); tick();

        // Narrow perf counter saturation
        for (int i = 0; i < 18; i++) begin
            set_upd(1'b1, 32'h0040_1000 + 32'(i * 4), 1'b1, 1'b1, 32'h0000_4000, 32'h0);
            step();
        end
        upd_valid = 1'b0;
        half();
        chk("perf sat", mc1, 4'hF);
        chk("perf wide", mc0, 32'd18);
        tick();

        // Randomized traffic over a small aliasing PC pool
        for (int i = 0; i < 600; i++) begin
            pcr = 32'h0040_0000 + (($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2));
            upd_valid     = ($urandom_range(0, 3) != 0);
            upd_pc        = pcr;
            upd_is_branch = ($urandom_range(0, 4) != 0);
            upd_taken     = $urandom_range(0, 1) == 1;
            upd_target    = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            case ($urandom_range(0, 2))
                0: begin predict(0, pcr, h, t, pn); upd_pred_npc = pn; end
                1: upd_pred_npc = pcr + 32'd4;
                default: upd_pred_npc = upd_target;
            endcase
            upd_pred_taken = $urandom_range(0, 1) == 1;
            inv    = ($urandom_range(0, 49) == 0);
            lkp_pc = ($urandom_range(0, 3) == 0) ? pcr :
                     32'h0040_0000 + (($urandom_range(0, 3) << 8) | ($urandom_range(0, 63) << 2));
            step();
        end
        inv = 1'b0;
        upd_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
